// File: rtl/reg_write_arbiter.sv
// Purpose : shares the single register-bank write port between ID immediates and WB results.
// Latency : one registered stage; a request granted at edge N is on wr_* after edge N.
// Backpres: o_wb_stall (comb) holds WB only on a forced drain; o_id_stall parks ID after a conflict.
//
// Ports
//   i_clk, i_rst_n                     clock (rising edge), async active-low reset
//   i_imm_req / i_imm_dst / i_imm_data ID-stage immediate write request
//   i_wb_req  / i_wb_dst  / i_wb_data  WB-stage result write request
//   o_wr_en / o_wr_addr / o_wr_data    registered register-bank write port
//   o_wr_sel                           registered source of the write: 1=WB, 0=immediate
//   o_id_stall                         registered: parked immediate pending
//   o_wb_stall                         combinational: WB request not accepted this cycle
//   o_proto_err                        sticky: imm request seen while ID was stalled
module reg_write_arbiter #(
  parameter int ARQ        = 16,
  parameter int RAW        = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_imm_req,
  input  logic [RAW-1:0] i_imm_dst,
  input  logic [ARQ-1:0] i_imm_data,
  input  logic           i_wb_req,
  input  logic [RAW-1:0] i_wb_dst,
  input  logic [ARQ-1:0] i_wb_data,
  output logic           o_wr_en,
  output logic [RAW-1:0] o_wr_addr,
  output logic [ARQ-1:0] o_wr_data,
  output logic           o_wr_sel,
  output logic           o_id_stall,
  output logic           o_wb_stall,
  output logic           o_proto_err
);

  localparam int AW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t         r_state;
  logic [AW-1:0]  r_age;
  logic [RAW-1:0] r_park_dst;
  logic [ARQ-1:0] r_park_data;
  logic           r_wr_en;
  logic [RAW-1:0] r_wr_addr;
  logic [ARQ-1:0] r_wr_data;
  logic           r_wr_sel;
  logic           r_id_stall;
  logic           r_proto_err;

  // The parked immediate has lost STARVE_MAX times in a row: it takes the
  // port this cycle and WB is told to hold its request.
  logic w_force_drain;
  assign w_force_drain = (r_state == S_HELD) && (r_age == AW'(STARVE_MAX)) && i_wb_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_EMPTY;
      r_age       <= '0;
      r_park_dst  <= '0;
      r_park_data <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_sel    <= 1'b0;
      r_id_stall  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;

      // ID ignored the stall: the buffer is left untouched, error is sticky.
      if (i_imm_req && (r_state == S_HELD)) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        S_EMPTY: begin
          if (i_wb_req) begin
            // WB carries the older instruction, so it writes first.
            r_wr_en   <= 1'b1;
            r_wr_addr <= i_wb_dst;
            r_wr_data <= i_wb_data;
            r_wr_sel  <= 1'b1;
            if (i_imm_req) begin
              r_park_dst  <= i_imm_dst;
              r_park_data <= i_imm_data;
              r_age       <= AW'(1);
              r_state     <= S_HELD;
              r_id_stall  <= 1'b1;
            end
          end else if (i_imm_req) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= i_imm_dst;
            r_wr_data <= i_imm_data;
            r_wr_sel  <= 1'b0;
          end
        end

        S_HELD: begin
          if (!i_wb_req || w_force_drain) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_park_dst;
            r_wr_data  <= r_park_data;
            r_wr_sel   <= 1'b0;
            r_age      <= '0;
            r_state    <= S_EMPTY;
            r_id_stall <= 1'b0;
          end else begin
            // Here age < STARVE_MAX, so the increment cannot pass the limit.
            r_wr_en   <= 1'b1;
            r_wr_addr <= i_wb_dst;
            r_wr_data <= i_wb_data;
            r_wr_sel  <= 1'b1;
            r_age     <= r_age + AW'(1);
          end
        end

        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_wr_sel    = r_wr_sel;
  assign o_id_stall  = r_id_stall;
  assign o_wb_stall  = w_force_drain;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Purpose : self-checking bench for reg_write_arbiter (directed scenarios + random traffic).
// Latency : expects each write one edge after the request is accepted.
// Backpres: WB driver holds its request whenever wb_stall is reported; ID honours id_stall.
module tb_reg_write_arbiter;

  localparam int ARQ        = 16;
  localparam int RAW        = 3;
  localparam int STARVE_MAX = 4;

  logic           i_clk;
  logic           i_rst_n;
  logic           i_imm_req;
  logic [RAW-1:0] i_imm_dst;
  logic [ARQ-1:0] i_imm_data;
  logic           i_wb_req;
  logic [RAW-1:0] i_wb_dst;
  logic [ARQ-1:0] i_wb_data;
  logic           o_wr_en;
  logic [RAW-1:0] o_wr_addr;
  logic [ARQ-1:0] o_wr_data;
  logic           o_wr_sel;
  logic           o_id_stall;
  logic           o_wb_stall;
  logic           o_proto_err;

  reg_write_arbiter #(.ARQ(ARQ), .RAW(RAW), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_imm_req  (i_imm_req),
    .i_imm_dst  (i_imm_dst),
    .i_imm_data (i_imm_data),
    .i_wb_req   (i_wb_req),
    .i_wb_dst   (i_wb_dst),
    .i_wb_data  (i_wb_data),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_sel   (o_wr_sel),
    .o_id_stall (o_id_stall),
    .o_wb_stall (o_wb_stall),
    .o_proto_err(o_proto_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Edge counter: a write expected "after edge N" carries cyc value N.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    int             cyc;
    logic [RAW-1:0] addr;
    logic [ARQ-1:0] data;
    logic           sel;
  } wr_t;

  wr_t exp_q[$];
  wr_t last_wr;

  // Reference model: one parked immediate and the number of WB writes that
  // have gone ahead of it since it was parked.
  bit             m_pend;
  logic [RAW-1:0] m_pdst;
  logic [ARQ-1:0] m_pdata;
  int             m_wins;
  bit             m_perr;

  function automatic void push(input logic [RAW-1:0] a, input logic [ARQ-1:0] d, input logic s);
    wr_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    e.sel  = s;
    exp_q.push_back(e);
  endfunction

  // Monitor: checks every write the DUT presents against the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("lost_write_cycle", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(o_wr_en), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
          check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
          check("wr_data", 32'(o_wr_data), 32'(e.data));
          check("wr_sel", 32'(o_wr_sel), 32'(e.sel));
          last_wr = e;
        end
      end else begin
        check("idle_hold", {o_wr_sel, 3'b0, o_wr_addr, 9'b0, o_wr_data},
              {last_wr.sel, 3'b0, last_wr.addr, 9'b0, last_wr.data});
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge.
  task automatic step(input bit wr, input logic [RAW-1:0] wd, input logic [ARQ-1:0] wdt,
                      input bit ir, input logic [RAW-1:0] id, input logic [ARQ-1:0] idt,
                      output bit stalled);
    bit exp_stall, wb_acc, was_pend;
    i_wb_req   = wr;
    i_wb_dst   = wd;
    i_wb_data  = wdt;
    i_imm_req  = ir;
    i_imm_dst  = id;
    i_imm_data = idt;
    #2;
    was_pend  = m_pend;
    exp_stall = was_pend && (m_wins == STARVE_MAX) && wr;
    check("wb_stall", 32'(o_wb_stall), 32'(exp_stall));
    wb_acc = wr && !exp_stall;
    if (wb_acc) push(wd, wdt, 1'b1);
    if (was_pend) begin
      if (wb_acc) m_wins++;
      else begin
        push(m_pdst, m_pdata, 1'b0);
        m_pend = 0;
        m_wins = 0;
      end
      if (ir) m_perr = 1;
    end else if (ir) begin
      if (wb_acc) begin
        m_pend  = 1;
        m_pdst  = id;
        m_pdata = idt;
        m_wins  = 1;
      end else begin
        push(id, idt, 1'b0);
      end
    end
    stalled = exp_stall;
    @(posedge i_clk);
    #1;
    check("id_stall", 32'(o_id_stall), 32'(m_pend));
    check("proto_err", 32'(o_proto_err), 32'(m_perr));
  endtask

  task automatic idle(input int n);
    bit st;
    for (int k = 0; k < n; k++) step(0, '0, '0, 0, '0, '0, st);
  endtask

  task automatic do_reset();
    i_wb_req  = 0;
    i_imm_req = 0;
    i_rst_n   = 0;
    #1;
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_wr_sel", 32'(o_wr_sel), 32'd0);
    check("rst_id_stall", 32'(o_id_stall), 32'd0);
    check("rst_wb_stall", 32'(o_wb_stall), 32'd0);
    check("rst_proto_err", 32'(o_proto_err), 32'd0);
    m_pend  = 0;
    m_wins  = 0;
    m_perr  = 0;
    exp_q.delete();
    last_wr = '{cyc: 0, addr: '0, data: '0, sel: 1'b0};
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  initial begin
    bit             st;
    logic [RAW-1:0] wd;
    logic [ARQ-1:0] wdt;
    bit             wr, ir;

    i_rst_n    = 0;
    i_wb_req   = 0;
    i_wb_dst   = '0;
    i_wb_data  = '0;
    i_imm_req  = 0;
    i_imm_dst  = '0;
    i_imm_data = '0;
    last_wr    = '{cyc: 0, addr: '0, data: '0, sel: 1'b0};
    #6;
    do_reset();

    // Reset while an immediate is parked: it must never be written.
    step(1, 3'd1, 16'hAAAA, 1, 3'd6, 16'h0066, st);
    step(1, 3'd1, 16'hBBBB, 0, '0, '0, st);
    do_reset();
    idle(3);

    // Lone immediate.
    step(0, '0, '0, 1, 3'd3, 16'h00AB, st);
    idle(2);

    // Same-cycle tie to r2, then idle: WB then immediate.
    step(1, 3'd2, 16'h1234, 1, 3'd2, 16'h0007, st);
    idle(3);

    // Tie followed by sustained WB traffic: forced drain after STARVE_MAX wins.
    step(1, 3'd4, 16'h4000, 1, 3'd5, 16'h00AA, st);
    for (int i = 0; i < 6; i++) begin
      if (!st) begin
        wd  = 3'(i);
        wdt = 16'h2000 + 16'(i);
      end
      step(1, wd, wdt, 0, '0, '0, st);
    end
    idle(2);

    // Immediate issued against id_stall: ignored, error sticky, original drains.
    step(1, 3'd7, 16'h7777, 1, 3'd1, 16'h0011, st);
    step(1, 3'd7, 16'h7778, 1, 3'd1, 16'h0099, st);
    step(0, '0, '0, 0, '0, '0, st);
    idle(3);

    do_reset();

    // Random traffic honouring both stalls.
    st = 0;
    for (int i = 0; i < 500; i++) begin
      if (!st) begin
        wr  = ($urandom_range(0, 99) < 65);
        wd  = 3'($urandom_range(0, 7));
        wdt = 16'($urandom);
      end
      ir = !o_id_stall && ($urandom_range(0, 99) < 50);
      step(wr, wd, wdt, ir, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)), st);
    end
    idle(STARVE_MAX + 3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
